// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the cache-line memory bus controller.
package mem_bus_pkg;

    typedef enum logic [2:0] {IDLE, REQ, READ, WRITE, DONE} state_t;

    typedef enum logic {IC, DC} owner_t;

    localparam int BEATS_DEFAULT  = 8;
    localparam int DATA_W_DEFAULT = 64;
    localparam int TIMEOUT_CYCLES = 1024;

    // Number of byte-offset bits inside one cache line.
    function automatic int line_ofs_w(input int beats, input int data_w);
        return $clog2(beats * data_w / 8);
    endfunction

    localparam int LINE_OFS_W = line_ofs_w(BEATS_DEFAULT, DATA_W_DEFAULT);

endpackage

// File: rtl/mem_beat_counter.sv
// Beat counter for one cache line: advances on inc, wraps after BEATS beats,
// flags the final beat with last.
module mem_beat_counter #(
    parameter int BEATS = 8,
    parameter int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic last
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count_reg <= '0;
        end else if (inc) begin
            count_reg <= last ? '0 : count_reg + 1'b1;
        end
    end

    assign last = (count_reg == CNT_W'(BEATS - 1));

endmodule

// File: rtl/mem_bus_ctrl.sv
// Moves one cache line between the owning cache (I or D) and memory.
// Optional request timeout and line_err port: define MEM_BUS_CTRL_TIMEOUT_EN.
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int BEATS  = BEATS_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bus_grant1,
    input  logic              bus_grant2,
    input  logic [ADDR_W-1:0] ic_addr,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic              dc_write,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic [DATA_W-1:0] line_rdata,
    output logic              line_rvalid,
    output logic              wr_beat_ack,
    output logic              line_done,
`ifdef MEM_BUS_CTRL_TIMEOUT_EN
    output logic              line_err,
`endif
    output logic              bus_req,
    output logic [ADDR_W-1:0] bus_reqaddr,
    output logic              bus_reqwrite,
    input  logic              bus_reqack,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_respcyc,
    output logic              bus_respack
);

    localparam int OFS_W = line_ofs_w(BEATS, DATA_W);

    state_t            state_reg, state_next;
    owner_t            owner_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              write_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              rvalid_reg;
    logic              done_reg;

    logic [ADDR_W-1:0] line_mask;
    logic              load;
    logic              beat_inc;
    logic              beat_last;
    logic              owner_grant;
    logic              timeout_hit;

    generate
        for (genvar gi = 0; gi < ADDR_W; gi++) begin : g_mask
            assign line_mask[gi] = (gi >= OFS_W);
        end
    endgenerate

    assign owner_grant = (owner_reg == DC) ? bus_grant2 : bus_grant1;

    mem_beat_counter #(
        .BEATS (BEATS)
    ) u_beat_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (beat_inc),
        .clr   (state_reg == IDLE),
        .last  (beat_last)
    );

`ifdef MEM_BUS_CTRL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);

    logic [TO_W-1:0] to_cnt_reg;
    logic            err_reg;

    // Counts consecutive unacknowledged REQ cycles; fires on the last one.
    assign timeout_hit = (state_reg == REQ) && !bus_reqack
                         && (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            to_cnt_reg <= ((state_reg == REQ) && !bus_reqack) ? to_cnt_reg + 1'b1 : '0;
            err_reg    <= timeout_hit;
        end
    end

    assign line_err = err_reg;
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        beat_inc   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus_grant1 || bus_grant2) begin
                    load       = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (bus_reqack) begin
                    state_next = write_reg ? WRITE : READ;
                end else if (timeout_hit) begin
                    state_next = DONE;
                end
            end
            READ: begin
                beat_inc = bus_respcyc;
                if (bus_respcyc && beat_last) begin
                    state_next = DONE;
                end
            end
            WRITE: begin
                beat_inc = 1'b1;
                if (beat_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // Hold here while the owner keeps its grant so it cannot re-request.
                if (!owner_grant) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            owner_reg  <= IC;
            addr_reg   <= '0;
            write_reg  <= 1'b0;
            rdata_reg  <= '0;
            rvalid_reg <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (load) begin
                owner_reg <= bus_grant2 ? DC : IC;
                addr_reg  <= (bus_grant2 ? dc_addr : ic_addr) & line_mask;
                write_reg <= bus_grant2 & dc_write;
            end
            rvalid_reg <= (state_reg == READ) && bus_respcyc;
            if ((state_reg == READ) && bus_respcyc) begin
                rdata_reg <= bus_rdata;
            end
            done_reg <= (state_reg != DONE) && (state_next == DONE);
        end
    end

    assign bus_req      = (state_reg == REQ);
    assign bus_reqaddr  = bus_req ? addr_reg : '0;
    assign bus_reqwrite = bus_req & write_reg;
    assign bus_respack  = (state_reg == READ) & bus_respcyc;
    assign wr_beat_ack  = (state_reg == WRITE);
    assign bus_wdata    = wr_beat_ack ? dc_wdata : '0;
    assign line_rdata   = rdata_reg;
    assign line_rvalid  = rvalid_reg;
    assign line_done    = done_reg;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: table of line transactions plus reset,
// grant-hold and (with MEM_BUS_CTRL_TIMEOUT_EN) request-timeout sequences.
module tb_mem_bus_ctrl;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int BEATS  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              bus_grant1, bus_grant2;
    logic [ADDR_W-1:0] ic_addr, dc_addr;
    logic              dc_write;
    logic [DATA_W-1:0] dc_wdata;
    logic [DATA_W-1:0] line_rdata;
    logic              line_rvalid, wr_beat_ack, line_done;
`ifdef MEM_BUS_CTRL_TIMEOUT_EN
    logic              line_err;
`endif
    logic              bus_req;
    logic [ADDR_W-1:0] bus_reqaddr;
    logic              bus_reqwrite, bus_reqack;
    logic [DATA_W-1:0] bus_wdata, bus_rdata;
    logic              bus_respcyc, bus_respack;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_bus_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .BEATS  (BEATS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus_grant1   (bus_grant1),
        .bus_grant2   (bus_grant2),
        .ic_addr      (ic_addr),
        .dc_addr      (dc_addr),
        .dc_write     (dc_write),
        .dc_wdata     (dc_wdata),
        .line_rdata   (line_rdata),
        .line_rvalid  (line_rvalid),
        .wr_beat_ack  (wr_beat_ack),
        .line_done    (line_done),
`ifdef MEM_BUS_CTRL_TIMEOUT_EN
        .line_err     (line_err),
`endif
        .bus_req      (bus_req),
        .bus_reqaddr  (bus_reqaddr),
        .bus_reqwrite (bus_reqwrite),
        .bus_reqack   (bus_reqack),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata),
        .bus_respcyc  (bus_respcyc),
        .bus_respack  (bus_respack)
    );

    typedef struct {
        logic              g1;
        logic              g2;
        logic              wr;
        logic [ADDR_W-1:0] ic;
        logic [ADDR_W-1:0] dc;
        logic [ADDR_W-1:0] exp_addr;
        int                ack_delay;
        int                gap;
        int                hold;
        logic [DATA_W-1:0] base;
    } txn_t;

    txn_t txns[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Wait for bus_req, check the request, then ack after ack_delay extra cycles.
    task automatic req_phase(input txn_t t, input string tag);
        logic seen;
        logic stable;
        seen = 1'b0;
        for (int k = 0; k < 4 && !seen; k++) begin
            @(posedge clk); #1;
            seen = bus_req;
        end
        chk({tag, " bus_req"}, 64'(seen), 64'd1);
        if (!seen) return;
        chk({tag, " reqaddr"}, bus_reqaddr, t.exp_addr);
        chk({tag, " reqwrite"}, 64'(bus_reqwrite), 64'(t.wr & t.g2));
        stable = 1'b1;
        for (int d = 0; d < t.ack_delay; d++) begin
            @(posedge clk); #1;
            if (!bus_req || bus_reqaddr !== t.exp_addr) stable = 1'b0;
        end
        chk({tag, " req stable"}, 64'(stable), 64'd1);
        bus_reqack = 1'b1;
        @(posedge clk); #1;
        bus_reqack = 1'b0;
    endtask

    // Runs the data beats; entered at posedge+1 of the first READ/WRITE cycle.
    task automatic data_phase(input txn_t t, input string tag);
        int sent = 0, rv = 0, acks = 0, dones = 0;
        int last_cyc = -10, done_cyc = -1, rv_at_done = -1, acks_at_done = -1;
        int bad_data = 0, bad_respack = 0;
        logic [DATA_W-1:0] wexp;
        bool_loop: for (int c = 0; c < 80; c++) begin
            if (line_rvalid) begin
                if (line_rdata !== t.base + 64'(rv)) bad_data++;
                rv++;
            end
            if (line_done) begin
                dones++;
                if (done_cyc < 0) begin
                    done_cyc     = c;
                    rv_at_done   = rv;
                    acks_at_done = acks;
                end
            end
            if (done_cyc >= 0) begin
                bus_respcyc = 1'b1;
                #1;
                if (bus_respack) bad_respack++;
            end else if (t.wr) begin
                bus_respcyc = 1'b0;
                if (wr_beat_ack) begin
                    wexp     = 64'hA0 + 64'(acks);
                    dc_wdata = wexp;
                    #1;
                    if (bus_wdata !== wexp) bad_data++;
                    acks++;
                    last_cyc = c;
                end else begin
                    #1;
                end
            end else if (sent < BEATS && (c % (t.gap + 1)) == 0) begin
                bus_respcyc = 1'b1;
                bus_rdata   = t.base + 64'(sent);
                #1;
                if (!bus_respack) bad_respack++;
                sent++;
                last_cyc = c;
            end else begin
                bus_respcyc = 1'b0;
                #1;
                if (bus_respack) bad_respack++;
            end
            if (done_cyc >= 0 && c >= done_cyc + 2) break;
            @(posedge clk); #1;
        end
        bus_respcyc = 1'b0;
        chk_i({tag, " done pulses"}, dones, 1);
        chk_i({tag, " done latency"}, done_cyc, last_cyc + 1);
        chk_i({tag, " rvalid count"}, t.wr ? acks_at_done : rv_at_done, BEATS);
        chk_i({tag, " other count"}, t.wr ? rv : acks, 0);
        chk_i({tag, " beat data"}, bad_data, 0);
        chk_i({tag, " respack"}, bad_respack, 0);
        chk({tag, " no req in DONE"}, 64'(bus_req), 64'd0);
    endtask

    task automatic run_txn(input txn_t t, input string tag);
        int held = 0;
        bus_grant1 = t.g1;
        bus_grant2 = t.g2;
        ic_addr    = t.ic;
        dc_addr    = t.dc;
        dc_write   = t.wr;
        dc_wdata   = '0;
        req_phase(t, tag);
        data_phase(t, tag);
        for (int h = 0; h < t.hold; h++) begin
            @(posedge clk); #1;
            if (bus_req) held++;
        end
        chk_i({tag, " req while grant held"}, held, 0);
        bus_grant1 = 1'b0;
        bus_grant2 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk({tag, " idle after drop"}, 64'(bus_req | line_done | wr_beat_ack), 64'd0);
        $display("%s: addr=0x%0h write=%0d exp_reqaddr=0x%0h done", tag,
                 t.g2 ? t.dc : t.ic, t.wr & t.g2, t.exp_addr);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t rt;
        //            g1    g2    wr    ic            dc                     exp_addr               ack gap hold base
        txns[0] = '{1'b1, 1'b0, 1'b0, 64'h1038, 64'h0,                 64'h1000,              3, 0, 0,  64'h100};
        txns[1] = '{1'b0, 1'b1, 1'b1, 64'h0,    64'h2040,              64'h2040,              1, 0, 10, 64'h0};
        txns[2] = '{1'b1, 1'b0, 1'b0, 64'h3007, 64'h0,                 64'h3000,              0, 2, 0,  64'h300};
        txns[3] = '{1'b1, 1'b1, 1'b0, 64'h5000, 64'h40FF,              64'h40C0,              1, 1, 0,  64'h400};
        txns[4] = '{1'b1, 1'b1, 1'b1, 64'h5000, 64'hFFFFFFFFFFFFFFFF,  64'hFFFFFFFFFFFFFFC0,  0, 0, 0,  64'h0};

        reset       = 1'b1;
        bus_grant1  = 1'b0;
        bus_grant2  = 1'b0;
        ic_addr     = '0;
        dc_addr     = '0;
        dc_write    = 1'b0;
        dc_wdata    = 64'hDEAD;
        bus_reqack  = 1'b0;
        bus_rdata   = 64'hBEEF;
        bus_respcyc = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset bus_req", 64'(bus_req), 64'd0);
        chk("reset respack", 64'(bus_respack), 64'd0);
        chk("reset outputs", 64'(line_rvalid | line_done | wr_beat_ack | bus_reqwrite), 64'd0);
        chk("reset wdata", bus_wdata, 64'd0);
        bus_respcyc = 1'b0;
        reset       = 1'b0;
        @(posedge clk); #1;
        $display("reset: outputs checked idle");

        for (int i = 0; i < 5; i++) begin
            run_txn(txns[i], $sformatf("txn%0d", i));
        end

        // Reset three beats into a read; held grant must restart from beat 0.
        rt = '{1'b1, 1'b0, 1'b0, 64'h7010, 64'h0, 64'h7000, 0, 0, 0, 64'h700};
        bus_grant1 = 1'b1;
        ic_addr    = rt.ic;
        req_phase(rt, "rst pre");
        for (int b = 0; b < 3; b++) begin
            bus_respcyc = 1'b1;
            bus_rdata   = 64'h9900 + 64'(b);
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst mid rvalid", 64'(line_rvalid), 64'd0);
        chk("rst mid rdata", line_rdata, 64'd0);
        chk("rst mid respack", 64'(bus_respack), 64'd0);
        chk("rst mid req", 64'(bus_req | line_done | wr_beat_ack), 64'd0);
        chk("rst mid reqaddr", bus_reqaddr, 64'd0);
        reset       = 1'b0;
        bus_respcyc = 1'b0;
        req_phase(rt, "rst restart");
        data_phase(rt, "rst restart");
        bus_grant1 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        $display("rst: reset after 3 beats, restarted line 0x%0h", rt.exp_addr);

`ifdef MEM_BUS_CTRL_TIMEOUT_EN
        begin
            int   req_cycles = 0;
            logic got        = 1'b0;
            logic err        = 1'b0;
            bus_grant1 = 1'b1;
            ic_addr    = 64'h8000;
            for (int c = 0; c < 1100 && !got; c++) begin
                @(posedge clk); #1;
                if (bus_req) req_cycles++;
                if (line_done) begin
                    got = 1'b1;
                    err = line_err;
                end
            end
            chk("timeout done", 64'(got), 64'd1);
            chk("timeout err", 64'(err), 64'd1);
            chk_i("timeout req cycles", req_cycles, 1024);
            bus_grant1 = 1'b0;
            @(posedge clk); #1;
            @(posedge clk); #1;
            $display("timeout: req_cycles=%0d", req_cycles);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
